// File: rtl/uart_register_responder.sv
// Far-end UART packet responder: decodes host read/write requests, drives a 32-bit
// register bus and streams the response packet back through the transmitter handshake.
module uart_register_responder #(
  parameter int unsigned TIMEOUT      = 5_000_000,
  parameter int unsigned READ_TIMEOUT = 255
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  output logic        opRdEnable,
  input  logic [31:0] ipRdData,
  input  logic        ipRdValid
);

  localparam int unsigned TimerWidth   = $clog2(TIMEOUT + 1);
  localparam int unsigned RdTimerWidth = $clog2(READ_TIMEOUT + 1);
  localparam logic [TimerWidth-1:0]   TimerLast   = TimerWidth'(TIMEOUT - 1);
  localparam logic [RdTimerWidth-1:0] RdTimerLast = RdTimerWidth'(READ_TIMEOUT - 1);

  localparam logic [7:0] SyncByte = 8'h55;
  localparam logic [7:0] OkByte   = 8'hAA;
  localparam logic [7:0] ErrByte  = 8'hEE;

  typedef enum logic [3:0] {
    StSync,
    StCmd,
    StAddr,
    StData,
    StRegWrite,
    StRegRead,
    StReadWait,
    StTxLoad,
    StTxWaitBusy,
    StTxDone
  } state_e;

  state_e                  stateQ, stateD;
  logic                    isWriteQ, isWriteD;
  logic [7:0]              addrQ, addrD;
  logic [31:0]             wrDataQ, wrDataD;
  logic [23:0]             shiftQ, shiftD;
  logic [1:0]              byteCntQ, byteCntD;
  logic [TimerWidth-1:0]   timerQ, timerD;
  logic [RdTimerWidth-1:0] rdTimerQ, rdTimerD;
  logic [5:0][7:0]         respQ, respD;
  logic [2:0]              respLastQ, respLastD;
  logic [2:0]              txIdxQ, txIdxD;
  logic                    inPacket;
  logic                    byteTimeout;

  assign inPacket    = (stateQ == StCmd) || (stateQ == StAddr) || (stateQ == StData);
  assign byteTimeout = !ipRxValid && (timerQ == TimerLast);

  assign opAddress = addrQ;
  assign opWrData  = wrDataQ;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      stateQ    <= StSync;
      isWriteQ  <= 1'b0;
      addrQ     <= '0;
      wrDataQ   <= '0;
      shiftQ    <= '0;
      byteCntQ  <= '0;
      timerQ    <= '0;
      rdTimerQ  <= '0;
      respQ     <= '0;
      respLastQ <= '0;
      txIdxQ    <= '0;
    end else begin
      stateQ    <= stateD;
      isWriteQ  <= isWriteD;
      addrQ     <= addrD;
      wrDataQ   <= wrDataD;
      shiftQ    <= shiftD;
      byteCntQ  <= byteCntD;
      timerQ    <= timerD;
      rdTimerQ  <= rdTimerD;
      respQ     <= respD;
      respLastQ <= respLastD;
      txIdxQ    <= txIdxD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    isWriteD   = isWriteQ;
    addrD      = addrQ;
    wrDataD    = wrDataQ;
    shiftD     = shiftQ;
    byteCntD   = byteCntQ;
    timerD     = '0;
    rdTimerD   = '0;
    respD      = respQ;
    respLastD  = respLastQ;
    txIdxD     = txIdxQ;
    opWrEnable = 1'b0;
    opRdEnable = 1'b0;
    opTxSend   = 1'b0;
    opTxData   = 8'h00;

    // Idle-cycle counter only runs mid-packet; any received byte clears it.
    if (inPacket && !ipRxValid && (timerQ != TimerLast)) begin
      timerD = timerQ + 1'b1;
    end

    unique case (stateQ)
      StSync: begin
        if (ipRxValid && (ipRxData == SyncByte)) begin
          stateD = StCmd;
        end
      end
      StCmd: begin
        if (ipRxValid) begin
          if (ipRxData == 8'h00) begin
            isWriteD = 1'b0;
            stateD   = StAddr;
          end else if (ipRxData == 8'h01) begin
            isWriteD = 1'b1;
            stateD   = StAddr;
          end else begin
            stateD = StSync;
          end
        end else if (byteTimeout) begin
          stateD = StSync;
        end
      end
      StAddr: begin
        if (ipRxValid) begin
          addrD    = ipRxData;
          byteCntD = '0;
          stateD   = isWriteQ ? StData : StRegRead;
        end else if (byteTimeout) begin
          stateD = StSync;
        end
      end
      StData: begin
        // Partial data lives in shiftQ so an aborted packet never disturbs opWrData.
        if (ipRxValid) begin
          if (byteCntQ == 2'd3) begin
            wrDataD = {ipRxData, shiftQ};
            stateD  = StRegWrite;
          end else begin
            shiftD   = {ipRxData, shiftQ[23:8]};
            byteCntD = byteCntQ + 2'd1;
          end
        end else if (byteTimeout) begin
          stateD = StSync;
        end
      end
      StRegWrite: begin
        opWrEnable = 1'b1;
        respD[0]   = OkByte;
        respD[1]   = addrQ;
        respLastD  = 3'd1;
        txIdxD     = '0;
        stateD     = StTxLoad;
      end
      StRegRead: begin
        opRdEnable = 1'b1;
        stateD     = StReadWait;
      end
      StReadWait: begin
        if (ipRdValid) begin
          respD[0]  = OkByte;
          respD[1]  = addrQ;
          respD[2]  = ipRdData[7:0];
          respD[3]  = ipRdData[15:8];
          respD[4]  = ipRdData[23:16];
          respD[5]  = ipRdData[31:24];
          respLastD = 3'd5;
          txIdxD    = '0;
          stateD    = StTxLoad;
        end else if (rdTimerQ == RdTimerLast) begin
          respD[0]  = ErrByte;
          respD[1]  = addrQ;
          respLastD = 3'd1;
          txIdxD    = '0;
          stateD    = StTxLoad;
        end else begin
          rdTimerD = rdTimerQ + 1'b1;
        end
      end
      StTxLoad: begin
        opTxData = respQ[txIdxQ];
        if (!ipTxBusy) begin
          stateD = StTxWaitBusy;
        end
      end
      StTxWaitBusy: begin
        opTxData = respQ[txIdxQ];
        opTxSend = 1'b1;
        if (ipTxBusy) begin
          if (txIdxQ == respLastQ) begin
            stateD = StTxDone;
          end else begin
            txIdxD = txIdxQ + 3'd1;
            stateD = StTxLoad;
          end
        end
      end
      StTxDone: begin
        if (!ipTxBusy) begin
          stateD = StSync;
        end
      end
      default: stateD = StSync;
    endcase
  end

endmodule

// File: tb/tb_uart_register_responder.sv
// Randomised bench for uart_register_responder: packet-level scoreboard of expected bus
// strobes and response bytes, with a behavioural UART transmitter and register file.
module tb_uart_register_responder;

  localparam int unsigned TimeoutCycles     = 200;
  localparam int unsigned ReadTimeoutCycles = 255;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxSend;
  logic        ipTxBusy;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic        opRdEnable;
  logic [31:0] ipRdData;
  logic        ipRdValid;

  uart_register_responder #(
    .TIMEOUT      (TimeoutCycles),
    .READ_TIMEOUT (ReadTimeoutCycles)
  ) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxData   (ipRxData),
    .ipRxValid  (ipRxValid),
    .opTxData   (opTxData),
    .opTxSend   (opTxSend),
    .ipTxBusy   (ipTxBusy),
    .opAddress  (opAddress),
    .opWrData   (opWrData),
    .opWrEnable (opWrEnable),
    .opRdEnable (opRdEnable),
    .ipRdData   (ipRdData),
    .ipRdValid  (ipRdValid)
  );

  always #5 ipClk = ~ipClk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int rdEnCycle  = -1;
  int sendCycle  = -1;

  logic [7:0]  txExp[$];
  logic [7:0]  rdExp[$];
  logic [39:0] wrExp[$];
  logic [7:0]  stream[$];
  logic [31:0] regMem[0:255];
  bit          rdResponsive = 1'b1;
  int          rdDelay      = 1;

  always @(posedge ipClk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Bus monitor: every strobe must match the next expected transaction.
  initial begin
    forever begin
      @(negedge ipClk);
      if (ipReset) begin
        if (opWrEnable) begin
          if (wrExp.size() == 0) flag("unexpected write", {opAddress, opWrData});
          else check("write addr/data", {opAddress, opWrData}, wrExp.pop_front());
        end
        if (opRdEnable) begin
          rdEnCycle = cycle;
          if (rdExp.size() == 0) flag("unexpected read", opAddress);
          else check("read addr", opAddress, rdExp.pop_front());
        end
      end
    end
  end

  // Register file: answers reads after rdDelay cycles when responsive.
  initial begin
    logic [7:0] a;
    ipRdValid = 1'b0;
    ipRdData  = '0;
    forever begin
      @(negedge ipClk);
      if (ipReset && opRdEnable && rdResponsive) begin
        a = opAddress;
        repeat (rdDelay) @(posedge ipClk);
        #1;
        ipRdValid = 1'b1;
        ipRdData  = regMem[a];
        @(posedge ipClk);
        #1;
        ipRdValid = 1'b0;
        ipRdData  = $urandom;
      end
    end
  end

  // UART transmitter: latches the byte when it raises busy, then stays busy a while.
  initial begin
    logic [7:0] b;
    int d;
    ipTxBusy = 1'b0;
    forever begin
      @(negedge ipClk);
      if (ipReset && opTxSend && !ipTxBusy) begin
        b = opTxData;
        if (sendCycle < 0) sendCycle = cycle;
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          @(negedge ipClk);
          check("tx send/data held", {opTxSend, opTxData}, {1'b1, b});
        end
        @(posedge ipClk);
        #1;
        ipTxBusy = 1'b1;
        if (txExp.size() == 0) flag("unexpected tx byte", b);
        else check("tx byte", b, txExp.pop_front());
        repeat ($urandom_range(2, 8)) @(posedge ipClk);
        #1;
        ipTxBusy = 1'b0;
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    @(posedge ipClk);
    #1;
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(posedge ipClk);
    #1;
    ipRxValid = 1'b0;
    ipRxData  = $urandom;
  endtask

  task automatic sendStream();
    foreach (stream[i]) begin
      repeat ($urandom_range(0, 3)) @(posedge ipClk);
      sendByte(stream[i]);
    end
    stream.delete();
  endtask

  task automatic expectRead(input logic [7:0] addr, input bit responsive);
    logic [31:0] d = regMem[addr];
    rdExp.push_back(addr);
    if (responsive) begin
      txExp.push_back(8'hAA);
      txExp.push_back(addr);
      for (int i = 0; i < 4; i++) txExp.push_back(d[8*i +: 8]);
    end else begin
      txExp.push_back(8'hEE);
      txExp.push_back(addr);
    end
  endtask

  task automatic expectWrite(input logic [7:0] addr, input logic [31:0] data);
    wrExp.push_back({addr, data});
    txExp.push_back(8'hAA);
    txExp.push_back(addr);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((txExp.size() != 0 || rdExp.size() != 0 || wrExp.size() != 0 || ipTxBusy)
           && n < 3000) begin
      @(posedge ipClk);
      n++;
    end
    if (txExp.size() != 0 || rdExp.size() != 0 || wrExp.size() != 0 || ipTxBusy) begin
      flag({name, " never completed, pending"}, txExp.size() + rdExp.size() + wrExp.size());
      txExp.delete();
      rdExp.delete();
      wrExp.delete();
    end
    repeat (4) @(posedge ipClk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded its time limit, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  g;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          isWrite;
    bit          resp;
    int          n;

    for (int i = 0; i < 256; i++) regMem[i] = $urandom;
    ipReset   = 1'b0;
    ipRxData  = '0;
    ipRxValid = 1'b0;
    repeat (3) @(posedge ipClk);
    #1;
    check("reset outputs", {opTxData, opTxSend, opAddress, opWrData, opWrEnable, opRdEnable}, '0);
    ipReset = 1'b1;
    repeat (2) @(posedge ipClk);

    // Write with literal expectations.
    wrExp.push_back({8'h10, 32'h12345678});
    txExp.push_back(8'hAA);
    txExp.push_back(8'h10);
    stream = '{8'h55, 8'h01, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12};
    sendStream();
    waitIdle("write 0x10");
    check("address hold", opAddress, 8'h10);
    check("write data hold", opWrData, 32'h12345678);

    // Read with literal response bytes.
    regMem[8'h22] = 32'hDEADBEEF;
    rdDelay = 3;
    rdExp.push_back(8'h22);
    txExp = '{8'hAA, 8'h22, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stream = '{8'h55, 8'h00, 8'h22};
    sendStream();
    waitIdle("read 0x22");

    // Read timeout: register file silent.
    rdResponsive = 1'b0;
    rdEnCycle = -1;
    sendCycle = -1;
    rdExp.push_back(8'h05);
    txExp.push_back(8'hEE);
    txExp.push_back(8'h05);
    stream = '{8'h55, 8'h00, 8'h05};
    sendStream();
    waitIdle("read timeout 0x05");
    check("read timeout latency in 255..258", ((sendCycle - rdEnCycle) >= 255) &&
          ((sendCycle - rdEnCycle) <= 258), 1'b1);
    rdResponsive = 1'b1;

    // Garbage and bad command before a valid read.
    rdDelay = 2;
    expectRead(8'h01, 1'b1);
    stream = '{8'h00, 8'hFF, 8'h55, 8'h07, 8'h55, 8'h00, 8'h01};
    sendStream();
    waitIdle("garbage then read 0x01");

    // Inter-byte timeout aborts a partial write.
    stream = '{8'h55, 8'h01, 8'h10, 8'h78};
    sendStream();
    repeat (TimeoutCycles + 1) @(posedge ipClk);
    expectRead(8'h10, 1'b1);
    stream = '{8'h55, 8'h00, 8'h10};
    sendStream();
    waitIdle("read after abort");
    check("write data after abort", opWrData, 32'h12345678);

    // Randomised packets.
    for (int p = 0; p < 40; p++) begin
      isWrite = 1'($urandom_range(0, 1));
      addr    = 8'($urandom);
      data    = $urandom;
      resp    = ($urandom_range(0, 7) != 0);
      n       = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        g = 8'($urandom);
        if (g == 8'h55) g = 8'h54;
        stream.push_back(g);
      end
      if ($urandom_range(0, 5) == 0) begin
        stream.push_back(8'h55);
        stream.push_back(8'($urandom_range(2, 255)));
      end
      stream.push_back(8'h55);
      stream.push_back(isWrite ? 8'h01 : 8'h00);
      stream.push_back(addr);
      if (isWrite) begin
        for (int k = 0; k < 4; k++) stream.push_back(data[8*k +: 8]);
        expectWrite(addr, data);
      end else begin
        rdResponsive = resp;
        rdDelay      = $urandom_range(1, 6);
        expectRead(addr, resp);
      end
      sendStream();
      waitIdle("random packet");
      rdResponsive = 1'b1;
      if (isWrite) check("random write data hold", {opAddress, opWrData}, {addr, data});
    end

    // Asynchronous reset in the middle of a response.
    rdDelay = 1;
    expectRead(8'h33, 1'b1);
    stream = '{8'h55, 8'h00, 8'h33};
    sendStream();
    n = 0;
    while (!ipTxBusy && n < 1000) begin
      @(posedge ipClk);
      n++;
    end
    if (!ipTxBusy) flag("tx never started before reset", n);
    @(posedge ipClk);
    #3;
    ipReset = 1'b0;
    #1;
    check("async reset outputs", {opTxData, opTxSend, opAddress, opWrData, opWrEnable,
          opRdEnable}, '0);
    txExp.delete();
    rdExp.delete();
    repeat (3) @(posedge ipClk);
    #1;
    ipReset = 1'b1;
    waitIdle("uart drain after reset");
    expectRead(8'h44, 1'b1);
    stream = '{8'h55, 8'h00, 8'h44};
    sendStream();
    waitIdle("read after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
